// File: rtl/pill_alarm_seq.sv
// pill_alarm_seq: multi-compartment pill reminder sequencer.
// Rising edges on req[] latch per-channel alarm requests. Requests are served one
// at a time, lowest index first. Each burst is (ch+1) beeps, and a burst repeats
// REPEATS times with a silent gap between bursts. ack ends the served alarm early
// and pulses acked. An alarm that runs out without ack pulses missed.
// Optional feature macro: ALARM_ESCALATE_EN. When it is defined, the gaps shrink
// geometrically and the final burst sounds at twice the pitch.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req[N_CH]         per-channel alarm request (rising-edge sensitive)
//   ack               user acknowledge (level)
//   beep              buzzer drive (tone gated by envelope)
//   beep_env          envelope, high during pulse-on
//   active            an alarm is being sequenced
//   active_ch[CW]     index of served channel, 0 when idle
//   acked, missed     one-cycle end-of-alarm pulses
module pill_alarm_seq #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned PULSE_CYCLES = 20_000_000,
    parameter int unsigned GAP_CYCLES   = 500_000_000,
    parameter int unsigned REPEATS      = 3,
    parameter int unsigned TONE_DIV     = 25_000,
    localparam int unsigned CW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            ack,
    output logic            beep,
    output logic            beep_env,
    output logic            active,
    output logic [CW-1:0]   active_ch,
    output logic            acked,
    output logic            missed
);

    localparam int unsigned RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PULSE_ON  = 2'd1,
        S_PULSE_OFF = 2'd2,
        S_GAP       = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [CW-1:0]   pulse_idx_q, pulse_idx_d;
    logic [RW-1:0]   rep_q, rep_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] req_prev_q;
    logic            tone_q, tone_d;
    logic [31:0]     tone_cnt_q, tone_cnt_d;
    logic            beep_q, beep_d;
    logic            env_q, env_d;
    logic            active_q, active_d;
    logic            acked_q, acked_d;
    logic            missed_q, missed_d;

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] grant_mask;
    logic            grant_found;
    logic [CW-1:0]   grant_idx;
    logic [31:0]     gap_len;
    logic [31:0]     tone_div_eff;

    // Gap length and tone divider for the current repeat index
    always_comb begin
        gap_len      = 32'(GAP_CYCLES);
        tone_div_eff = 32'(TONE_DIV);
`ifdef ALARM_ESCALATE_EN
        // rep_q already names the upcoming burst while in GAP, so it is >= 1 there
        if (rep_q != RW'(0)) begin
            gap_len = 32'(GAP_CYCLES) >> (rep_q - RW'(1));
        end
        if (gap_len < 32'(PULSE_CYCLES)) begin
            gap_len = 32'(PULSE_CYCLES);
        end
        if (rep_q == REP_LAST) begin
            tone_div_eff = 32'(TONE_DIV / 2);
        end
`endif
    end

    // Lowest pending channel wins the grant
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (pending_q[i] && !grant_found) begin
                grant_found = 1'b1;
                grant_idx   = CW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and sequencing counters
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 32'd1;
        pulse_idx_d = pulse_idx_q;
        rep_d       = rep_q;
        ch_d        = ch_q;
        acked_d     = 1'b0;
        missed_d    = 1'b0;
        grant_mask  = '0;

        // A re-press on the channel being served is dropped rather than re-queued
        rise = req & ~req_prev_q;
        if (state_q != S_IDLE) begin
            rise = rise & ~(N_CH'(1) << ch_q);
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_found) begin
                    state_d     = S_PULSE_ON;
                    ch_d        = grant_idx;
                    pulse_idx_d = '0;
                    rep_d       = '0;
                    grant_mask  = N_CH'(1) << grant_idx;
                end
            end
            S_PULSE_ON: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_PULSE_OFF;
                    cnt_d   = '0;
                end
            end
            S_PULSE_OFF: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = '0;
                    if (pulse_idx_q < ch_q) begin
                        pulse_idx_d = pulse_idx_q + CW'(1);
                        state_d     = S_PULSE_ON;
                    end else if (rep_q == REP_LAST) begin
                        state_d  = S_IDLE;
                        missed_d = 1'b1;
                        ch_d     = '0;
                    end else begin
                        rep_d   = rep_q + RW'(1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == gap_len - 32'd1) begin
                    state_d     = S_PULSE_ON;
                    pulse_idx_d = '0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Acknowledge wins over any same-cycle transition, including the missed end
        if (ack && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            ch_d     = '0;
            acked_d  = 1'b1;
            missed_d = 1'b0;
        end

        pending_d = (pending_q | rise) & ~grant_mask;
    end

    // Output decode and tone generator, registered below
    always_comb begin
        tone_d     = tone_q;
        tone_cnt_d = tone_cnt_q;
        if ((state_d == S_PULSE_ON) && (state_q != S_PULSE_ON)) begin
            tone_d     = 1'b1;
            tone_cnt_d = '0;
        end else if (state_q == S_PULSE_ON) begin
            if (tone_div_eff == 32'd0) begin
                tone_d = 1'b1;
            end else if (tone_cnt_q == tone_div_eff - 32'd1) begin
                tone_d     = ~tone_q;
                tone_cnt_d = '0;
            end else begin
                tone_cnt_d = tone_cnt_q + 32'd1;
            end
        end
        env_d    = (state_d == S_PULSE_ON);
        active_d = (state_d != S_IDLE);
        beep_d   = env_d & tone_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            pulse_idx_q <= '0;
            rep_q       <= '0;
            ch_q        <= '0;
            pending_q   <= '0;
            req_prev_q  <= '0;
            tone_q      <= 1'b0;
            tone_cnt_q  <= '0;
            beep_q      <= 1'b0;
            env_q       <= 1'b0;
            active_q    <= 1'b0;
            acked_q     <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pulse_idx_q <= pulse_idx_d;
            rep_q       <= rep_d;
            ch_q        <= ch_d;
            pending_q   <= pending_d;
            req_prev_q  <= req;
            tone_q      <= tone_d;
            tone_cnt_q  <= tone_cnt_d;
            beep_q      <= beep_d;
            env_q       <= env_d;
            active_q    <= active_d;
            acked_q     <= acked_d;
            missed_q    <= missed_d;
        end
    end

    assign beep      = beep_q;
    assign beep_env  = env_q;
    assign active    = active_q;
    assign active_ch = ch_q;
    assign acked     = acked_q;
    assign missed    = missed_q;

endmodule

// File: tb/tb_pill_alarm_seq.sv
// Testbench for pill_alarm_seq: directed table, multi-cycle scenarios and random
// stimulus checked against a timeline-arithmetic reference model.
module tb_pill_alarm_seq;

    localparam int unsigned N_CH = 4;
    localparam int unsigned PC   = 4;
    localparam int unsigned GC   = 10;
    localparam int unsigned REP  = 2;
    localparam int unsigned TD   = 1;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       beep, beep_env, active, acked, missed;
    logic [1:0] active_ch;
    logic       beep0, beep_env0, active0, acked0, missed0;
    logic [1:0] active_ch0;

    int checks = 0;
    int errors = 0;

    pill_alarm_seq #(.N_CH(N_CH), .PULSE_CYCLES(PC), .GAP_CYCLES(GC), .REPEATS(REP),
                     .TONE_DIV(TD)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .beep(beep), .beep_env(beep_env),
        .active(active), .active_ch(active_ch), .acked(acked), .missed(missed));

    pill_alarm_seq #(.N_CH(N_CH), .PULSE_CYCLES(PC), .GAP_CYCLES(GC), .REPEATS(REP),
                     .TONE_DIV(0)) dut_dc (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .beep(beep0), .beep_env(beep_env0),
        .active(active0), .active_ch(active_ch0), .acked(acked0), .missed(missed0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which alarm is running and how far into its timeline it is
    bit       m_active;
    int       m_ch;
    int       m_k;
    bit [3:0] m_pending;
    bit [3:0] m_prev;
    bit       e_acked, e_missed;

    function automatic int burst_len(input int ch);
        return 2 * (ch + 1) * int'(PC);
    endfunction

    function automatic int alarm_len(input int ch);
        return int'(REP) * burst_len(ch) + (int'(REP) - 1) * int'(GC);
    endfunction

    function automatic int phase_pos();
        int w;
        w = m_k % (burst_len(m_ch) + int'(GC));
        if (w >= burst_len(m_ch)) return -1;
        return w % (2 * int'(PC));
    endfunction

    function automatic bit exp_env();
        int p;
        if (!m_active) return 1'b0;
        p = phase_pos();
        return (p >= 0) && (p < int'(PC));
    endfunction

    function automatic bit exp_beep(input int div);
        if (!exp_env()) return 1'b0;
        if (div == 0) return 1'b1;
        return ((phase_pos() / div) % 2) == 0;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_ch = 0; m_k = 0; m_pending = '0; m_prev = '0;
        e_acked = 1'b0; e_missed = 1'b0;
    endtask

    task automatic model_step();
        bit [3:0] rise, newp;
        int g;
        e_acked = 1'b0; e_missed = 1'b0;
        rise = req & ~m_prev;
        if (m_active) rise[m_ch] = 1'b0;
        newp = m_pending | rise;
        if (!m_active) begin
            g = -1;
            for (int i = int'(N_CH) - 1; i >= 0; i--) if (m_pending[i]) g = i;
            if (g >= 0) begin
                newp[g] = 1'b0; m_active = 1'b1; m_ch = g; m_k = 0;
            end
        end else if (ack) begin
            m_active = 1'b0; e_acked = 1'b1;
        end else begin
            m_k++;
            if (m_k == alarm_len(m_ch)) begin
                m_active = 1'b0; e_missed = 1'b1;
            end
        end
        m_pending = newp;
        m_prev = req;
    endtask

    task automatic chk(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic check_model();
        chk("env", int'(beep_env), int'(exp_env()));
        chk("beep", int'(beep), int'(exp_beep(int'(TD))));
        chk("active", int'(active), int'(m_active));
        chk("active_ch", int'(active_ch), m_active ? m_ch : 0);
        chk("acked", int'(acked), int'(e_acked));
        chk("missed", int'(missed), int'(e_missed));
        chk("dc_env", int'(beep_env0), int'(exp_env()));
        chk("dc_beep", int'(beep0), int'(exp_beep(0)));
    endtask

    // One clock: advance model at the edge, sample the DUT just after it
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_beep"}, int'(beep), 0);
        chk({tag, "_env"}, int'(beep_env), 0);
        chk({tag, "_active"}, int'(active), 0);
        chk({tag, "_ch"}, int'(active_ch), 0);
        chk({tag, "_acked"}, int'(acked), 0);
        chk({tag, "_missed"}, int'(missed), 0);
    endtask

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       active;
        logic [1:0] ch;
        logic       env;
        logic       beep;
        logic       acked;
        logic       missed;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int first_env, missed_at, rises, chbad, ack_seen, idle_gap, n_missed;
        int order[$];
        int rises_per[2];
        bit prev_env, prev_act;

        vecs[0] = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; req = '0; ack = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed table: req[0] alarm acked during its 2nd pulse-on cycle
        foreach (vecs[i]) begin
            req = vecs[i].req;
            ack = vecs[i].ack;
            cyc();
            chk($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].active));
            chk($sformatf("vec%0d_ch", i), int'(active_ch), int'(vecs[i].ch));
            chk($sformatf("vec%0d_env", i), int'(beep_env), int'(vecs[i].env));
            chk($sformatf("vec%0d_beep", i), int'(beep), int'(vecs[i].beep));
            chk($sformatf("vec%0d_acked", i), int'(acked), int'(vecs[i].acked));
            chk($sformatf("vec%0d_missed", i), int'(missed), int'(vecs[i].missed));
        end
        ack = 1'b0;

        // Channel 2 runs to the end without ack
        req = 4'b0100;
        first_env = -1; missed_at = -1; rises = 0; chbad = 0; ack_seen = 0; prev_env = 1'b0;
        for (int n = 0; n < 200; n++) begin
            cyc();
            if (n == 3) req = '0;
            if (beep_env && !prev_env) begin
                rises++;
                if (first_env < 0) first_env = n;
            end
            if (active && active_ch != 2'd2) chbad++;
            if (acked) ack_seen++;
            prev_env = beep_env;
            if (missed) begin
                missed_at = n;
                break;
            end
        end
        chk("ch2_missed_delay", missed_at - first_env, 58);
        chk("ch2_pulse_count", rises, 6);
        chk("ch2_ch_stable", chbad, 0);
        chk("ch2_no_ack", ack_seen, 0);
        req = '0;
        for (int n = 0; n < 3; n++) cyc();

        // Channels 3 and 1 rise together: 1 first, then 3 after one idle cycle
        req = 4'b1010;
        n_missed = 0; idle_gap = 0; prev_act = 1'b0; prev_env = 1'b0;
        rises_per[0] = 0; rises_per[1] = 0;
        for (int n = 0; n < 400 && n_missed < 2; n++) begin
            cyc();
            if (n == 2) req = '0;
            if (active && !prev_act) order.push_back(int'(active_ch));
            if (beep_env && !prev_env) rises_per[n_missed]++;
            if (missed) n_missed++;
            if (!active && n_missed == 1) idle_gap++;
            prev_act = active;
            prev_env = beep_env;
        end
        chk("pair_alarms", order.size(), 2);
        if (order.size() == 2) begin
            chk("pair_first_ch", order[0], 1);
            chk("pair_second_ch", order[1], 3);
        end
        chk("pair_ch1_pulses", rises_per[0], 4);
        chk("pair_ch3_pulses", rises_per[1], 8);
        chk("pair_idle_gap", idle_gap, 1);

        // Re-press of the served channel is ignored
        req = 4'b0010;
        for (int n = 0; n < 8; n++) cyc();
        req = '0;
        cyc();
        req = 4'b0010;
        missed_at = -1;
        for (int n = 0; n < 200; n++) begin
            cyc();
            if (missed) begin
                missed_at = n;
                break;
            end
        end
        chk("repress_ended", int'(missed_at >= 0), 1);
        req = '0;
        chbad = 0;
        for (int n = 0; n < 30; n++) begin
            cyc();
            if (active) chbad++;
        end
        chk("repress_not_requeued", chbad, 0);

        // Reset in the gap of a channel-0 alarm with channel 3 pending
        req = 4'b0001;
        cyc();
        cyc();
        req = '0;
        for (int n = 0; n < 3; n++) cyc();
        req = 4'b1000;
        for (int n = 0; n < 6; n++) cyc();
        chk("pre_reset_in_gap", int'(active && !beep_env), 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        req = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chbad = 0;
        for (int n = 0; n < 30; n++) begin
            cyc();
            if (active) chbad++;
        end
        chk("post_reset_idle", chbad, 0);

        // Random requests and acknowledges
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) req = req ^ 4'($urandom_range(0, 15));
            ack = ($urandom_range(0, 49) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
